// File: rtl/asyn_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters in bounded bursts.
// Define ASYN_FIFO_WARB_STATS_EN to add the stall_cnt output (cycles stalled by wfull).
module asyn_fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    wfull,
  output logic [DSIZE-1:0]        wdata,
  output logic                    winc,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
`ifdef ASYN_FIFO_WARB_STATS_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int unsigned OwnW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [OwnW-1:0] LastReq = OwnW'(NREQ - 1);
  localparam logic [OwnW:0]   NreqExt = (OwnW + 1)'(NREQ);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [OwnW-1:0]  owner_q, owner_d;
  logic [OwnW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [OwnW-1:0]  next_ptr;
  logic [CntW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [DSIZE-1:0] data_arr [NREQ];
  logic             accept;
  logic             burst_end;

  // First requester found scanning ptr, ptr+1, ... modulo NREQ.
  function automatic logic [OwnW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OwnW-1:0] ptr);
    logic [OwnW-1:0] win;
    logic [OwnW:0]   idx;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (OwnW + 1)'(i);
      if (idx >= NreqExt) idx = idx - NreqExt;
      if (!found && r[idx[OwnW-1:0]]) begin
        found = 1'b1;
        win   = idx[OwnW-1:0];
      end
    end
    return win;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign data_arr[g] = req_data[g*DSIZE +: DSIZE];
  end

  always_comb begin
    accept = wrst_n && (state_q == StBurst) && req[owner_q] && !wfull;
    winc   = accept;
    gnt    = '0;
    wdata  = '0;
    if (accept) begin
      gnt[owner_q] = 1'b1;
      wdata        = data_arr[owner_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    burst_end   = 1'b0;
    next_ptr    = (owner_q == LastReq) ? '0 : owner_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d     = StBurst;
          owner_d     = rr_pick(req, rr_ptr_q);
          burst_cnt_d = '0;
        end
      end
      StBurst: begin
        burst_end = (accept && (burst_cnt_q == CntLast)) || !req[owner_q];
        if (burst_end) begin
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
          // Scanning from owner+1 visits the old owner last, so it only wins when alone.
          if (|req) owner_d = rr_pick(req, next_ptr);
          else      state_d = StIdle;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == StBurst);

`ifdef ASYN_FIFO_WARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == StBurst) && req[owner_q] && wfull && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
